// File: rtl/prim_onehot_check_multi_pkg.sv
// rtl/prim_onehot_check_multi_pkg.sv - shared types for the multi-channel one-hot checker
// Contents: alert handshake state encoding, per-channel error cause struct,
// and the width of that struct.
package prim_onehot_check_multi_pkg;

    localparam int ErrCodeWidth = 3;

    typedef enum logic [1:0] {
        ALERT_IDLE = 2'b00,
        ALERT_REQ  = 2'b01,
        ALERT_ACK  = 2'b10
    } alert_state_e;

    typedef struct packed {
        logic addr_err;
        logic en_err;
        logic multihot_err;
    } err_code_t;

endpackage

// File: rtl/prim_onehot_check_core.sv
// rtl/prim_onehot_check_core.sv - combinational single-channel one-hot checker
// Ports:
//   oh    one-hot select vector of the channel
//   addr  binary address that should match the set bit of oh
//   en    channel enable that should match "any bit of oh set"
//   code  error causes {addr_err, en_err, multihot_err}
module prim_onehot_check_core
    import prim_onehot_check_multi_pkg::*;
#(
    parameter int unsigned AddrWidth   = 5,
    parameter int unsigned OneHotWidth = 2**AddrWidth,
    parameter bit          AddrCheck   = 1'b1,
    parameter bit          EnableCheck = 1'b1,
    parameter bit          StrictCheck = 1'b1
) (
    input  logic [OneHotWidth-1:0] oh,
    input  logic [AddrWidth-1:0]   addr,
    input  logic                   en,
    output err_code_t              code
);

    localparam int NumLeaves = 2**AddrWidth;
    localparam int NumNodes  = 2 * NumLeaves - 1;

    // Leaves beyond OneHotWidth are tied to 0, so an out-of-range address
    // selects a zero and the tree stays a full binary tree.
    logic [NumLeaves-1:0] leaves;
    logic [NumNodes-1:0]  or_tree;
    logic [NumNodes-1:0]  mh_tree;
    logic                 any_set;
    logic                 addr_bit;

    // Heap-ordered tree: node i has children 2i+1 and 2i+2, leaves occupy
    // the last NumLeaves slots. A node is multi-hot when either subtree is,
    // or when both subtrees have at least one bit set.
    always_comb begin
        leaves                  = '0;
        leaves[OneHotWidth-1:0] = oh;
        or_tree                 = '0;
        mh_tree                 = '0;
        for (int j = 0; j < NumLeaves; j++) begin
            or_tree[NumLeaves-1+j] = leaves[j];
        end
        for (int i = NumLeaves - 2; i >= 0; i--) begin
            or_tree[i] = or_tree[2*i+1] | or_tree[2*i+2];
            mh_tree[i] = mh_tree[2*i+1] | mh_tree[2*i+2]
                       | (or_tree[2*i+1] & or_tree[2*i+2]);
        end
    end

    assign any_set  = or_tree[0];
    assign addr_bit = leaves[addr];

    always_comb begin
        code              = '0;
        code.multihot_err = mh_tree[0];
        if (EnableCheck) begin
            code.en_err = StrictCheck ? (any_set ^ en) : (~en & any_set);
        end
        if (AddrCheck) begin
            code.addr_err = any_set ^ addr_bit;
        end
    end

endmodule

// File: rtl/prim_onehot_check_multi.sv
// rtl/prim_onehot_check_multi.sv - registered multi-channel one-hot integrity checker with alert
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   oh_i/addr_i/en_i per-channel one-hot vector, address and enable (channel c at c*W +: W)
//   chk_en_i         global check enable, sampled alongside the data
//   clr_i            clears sticky flags and error counter
//   err_o            registered per-channel error of the current sample
//   err_sticky_o     sticky per-channel error
//   err_cnt_o        saturating count of cycles with any error
//   alert_req_o      4-phase alert request, alert_ack_i its acknowledge
//   err_code_o       sticky per-channel {addr_err, en_err, multihot_err}
//                    (present only with PRIM_ONEHOT_CHECK_MULTI_ERRCODE_EN defined)
module prim_onehot_check_multi
    import prim_onehot_check_multi_pkg::*;
#(
    parameter int unsigned AddrWidth   = 5,
    parameter int unsigned OneHotWidth = 2**AddrWidth,
    parameter int unsigned NumCh       = 2,
    parameter bit          AddrCheck   = 1'b1,
    parameter bit          EnableCheck = 1'b1,
    parameter bit          StrictCheck = 1'b1,
    parameter int unsigned PipeStage   = 1,
    parameter int unsigned ErrCntWidth = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumCh*OneHotWidth-1:0] oh_i,
    input  logic [NumCh*AddrWidth-1:0]   addr_i,
    input  logic [NumCh-1:0]             en_i,
    input  logic                         chk_en_i,
    input  logic                         clr_i,
    output logic [NumCh-1:0]             err_o,
    output logic [NumCh-1:0]             err_sticky_o,
    output logic [ErrCntWidth-1:0]       err_cnt_o,
    output logic                         alert_req_o,
    input  logic                         alert_ack_i
`ifdef PRIM_ONEHOT_CHECK_MULTI_ERRCODE_EN
    ,
    output logic [NumCh*ErrCodeWidth-1:0] err_code_o
`endif
);

    localparam logic [ErrCntWidth-1:0] CntMax = '1;

    logic [NumCh*OneHotWidth-1:0] oh_s;
    logic [NumCh*AddrWidth-1:0]   addr_s;
    logic [NumCh-1:0]             en_s;
    logic                         chk_s;

    // chk_en_i travels with the data so gating lines up with the sample.
    if (PipeStage != 0) begin : g_pipe
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                oh_s   <= '0;
                addr_s <= '0;
                en_s   <= '0;
                chk_s  <= 1'b0;
            end else begin
                oh_s   <= oh_i;
                addr_s <= addr_i;
                en_s   <= en_i;
                chk_s  <= chk_en_i;
            end
        end
    end else begin : g_nopipe
        assign oh_s   = oh_i;
        assign addr_s = addr_i;
        assign en_s   = en_i;
        assign chk_s  = chk_en_i;
    end

    logic [NumCh-1:0] err_d;
    logic             err_any_d;
`ifdef PRIM_ONEHOT_CHECK_MULTI_ERRCODE_EN
    logic [NumCh*ErrCodeWidth-1:0] code_d;
    logic [NumCh*ErrCodeWidth-1:0] code_q;
`endif

    for (genvar c = 0; c < NumCh; c++) begin : g_ch
        err_code_t code_raw;

        prim_onehot_check_core #(
            .AddrWidth   (AddrWidth),
            .OneHotWidth (OneHotWidth),
            .AddrCheck   (AddrCheck),
            .EnableCheck (EnableCheck),
            .StrictCheck (StrictCheck)
        ) u_core (
            .oh   (oh_s[c*OneHotWidth +: OneHotWidth]),
            .addr (addr_s[c*AddrWidth +: AddrWidth]),
            .en   (en_s[c]),
            .code (code_raw)
        );

        assign err_d[c] = chk_s & (|code_raw);
`ifdef PRIM_ONEHOT_CHECK_MULTI_ERRCODE_EN
        assign code_d[c*ErrCodeWidth +: ErrCodeWidth] = chk_s ? code_raw : '0;
`endif
    end

    assign err_any_d = |err_d;

    // Sticky flags, counter and pending flag are loaded from the same value
    // that lands in err_o, so they move in the same cycle as err_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o        <= '0;
            err_sticky_o <= '0;
            err_cnt_o    <= '0;
        end else begin
            err_o        <= err_d;
            err_sticky_o <= clr_i ? err_d : (err_sticky_o | err_d);
            if (clr_i) begin
                err_cnt_o <= ErrCntWidth'(err_any_d);
            end else if (err_any_d && (err_cnt_o != CntMax)) begin
                err_cnt_o <= err_cnt_o + ErrCntWidth'(1);
            end
        end
    end

`ifdef PRIM_ONEHOT_CHECK_MULTI_ERRCODE_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            code_q <= '0;
        end else begin
            code_q <= clr_i ? code_d : (code_q | code_d);
        end
    end
    assign err_code_o = code_q;
`endif

    alert_state_e state_q;
    alert_state_e state_d;
    logic         pend_q;
    logic         leave_idle;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ALERT_IDLE: if (pend_q)       state_d = ALERT_REQ;
            ALERT_REQ:  if (alert_ack_i)  state_d = ALERT_ACK;
            ALERT_ACK:  if (!alert_ack_i) state_d = ALERT_IDLE;
            default:                      state_d = ALERT_IDLE;
        endcase
    end

    assign leave_idle = (state_q == ALERT_IDLE) && pend_q;

    // A new error arriving while the request is issued re-arms pending,
    // which yields exactly one more alert once the handshake completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ALERT_IDLE;
            pend_q      <= 1'b0;
            alert_req_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= err_any_d | (pend_q & ~leave_idle);
            alert_req_o <= (state_d == ALERT_REQ);
        end
    end

endmodule

// File: tb/tb_prim_onehot_check_multi.sv
// tb/tb_prim_onehot_check_multi.sv - randomized self-checking bench for prim_onehot_check_multi
module tb_prim_onehot_check_multi;

    localparam int AW = 3;
    localparam int OW = 8;
    localparam int NC = 2;
    localparam int CW = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NC*OW-1:0] oh;
    logic [NC*AW-1:0] addr;
    logic [NC-1:0]    en;
    logic             chk_en, clr, ack;
    logic [NC-1:0]    err_s, sticky_s, err_n, sticky_n;
    logic [CW-1:0]    cnt_s, cnt_n;
    logic             req_s, req_n;
`ifdef PRIM_ONEHOT_CHECK_MULTI_ERRCODE_EN
    logic [NC*3-1:0]  code_s, code_n;
`endif

    always #5 clk = ~clk;

    prim_onehot_check_multi #(
        .AddrWidth(AW), .NumCh(NC), .StrictCheck(1'b1), .PipeStage(1), .ErrCntWidth(CW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .oh_i(oh), .addr_i(addr), .en_i(en),
        .chk_en_i(chk_en), .clr_i(clr), .err_o(err_s), .err_sticky_o(sticky_s),
        .err_cnt_o(cnt_s), .alert_req_o(req_s), .alert_ack_i(ack)
`ifdef PRIM_ONEHOT_CHECK_MULTI_ERRCODE_EN
        , .err_code_o(code_s)
`endif
    );

    prim_onehot_check_multi #(
        .AddrWidth(AW), .NumCh(NC), .StrictCheck(1'b0), .PipeStage(1), .ErrCntWidth(CW)
    ) dut_ns (
        .clk_i(clk), .rst_ni(rst_n), .oh_i(oh), .addr_i(addr), .en_i(en),
        .chk_en_i(chk_en), .clr_i(clr), .err_o(err_n), .err_sticky_o(sticky_n),
        .err_cnt_o(cnt_n), .alert_req_o(req_n), .alert_ack_i(ack)
`ifdef PRIM_ONEHOT_CHECK_MULTI_ERRCODE_EN
        , .err_code_o(code_n)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    bit auto_ack = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [NC*OW-1:0] oh;
        logic [NC*AW-1:0] addr;
        logic [NC-1:0]    en;
        logic             chk;
    } sample_t;

    sample_t       hist[$];
    logic [NC-1:0] m_err[2];
    logic [NC-1:0] m_sticky[2];
    int            m_cnt[2];
    bit            m_pend[2];
    int            m_phase[2];   // 0 idle, 1 request raised, 2 waiting for ack release

    // Expected per-channel error of one sample, straight from the rules:
    // more than one bit set, enable disagreeing with "any bit", or the
    // addressed bit disagreeing with "any bit".
    function automatic logic [NC-1:0] ref_err(input sample_t s, input bit strict);
        logic [NC-1:0] r = '0;
        for (int c = 0; c < NC; c++) begin
            int ones = 0;
            int a;
            bit hit, anyb, e, bad;
            for (int b = 0; b < OW; b++) ones += int'(s.oh[c*OW+b]);
            a    = int'(s.addr[c*AW +: AW]);
            hit  = (a < OW) && s.oh[c*OW+a];
            anyb = ones > 0;
            e    = s.en[c];
            bad  = (ones > 1) || (strict ? (anyb != e) : (!e && anyb)) || (anyb != hit);
            r[c] = s.chk && bad;
        end
        return r;
    endfunction

    task automatic model_reset();
        sample_t z;
        z = '{default: '0};
        hist.delete();
        hist.push_back(z);
        for (int m = 0; m < 2; m++) begin
            m_err[m] = '0; m_sticky[m] = '0; m_cnt[m] = 0; m_pend[m] = 0; m_phase[m] = 0;
        end
    endtask

    // One clock edge of the reference: the sample seen one edge ago is what
    // err_o now reports.
    task automatic model_step();
        sample_t cur;
        cur.oh = oh; cur.addr = addr; cur.en = en; cur.chk = chk_en;
        hist.push_back(cur);
        for (int m = 0; m < 2; m++) begin
            logic [NC-1:0] e;
            bit anye, leave;
            e     = ref_err(hist[0], m == 0);
            anye  = |e;
            leave = (m_phase[m] == 0) && m_pend[m];
            case (m_phase[m])
                0: if (m_pend[m]) m_phase[m] = 1;
                1: if (ack)       m_phase[m] = 2;
                default: if (!ack) m_phase[m] = 0;
            endcase
            m_pend[m]   = anye || (m_pend[m] && !leave);
            m_sticky[m] = clr ? e : (m_sticky[m] | e);
            if (clr) m_cnt[m] = anye ? 1 : 0;
            else if (anye && m_cnt[m] < 255) m_cnt[m]++;
            m_err[m] = e;
        end
        void'(hist.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_val("err_strict",    32'(err_s),    32'(m_err[0]));
        check_val("sticky_strict", 32'(sticky_s), 32'(m_sticky[0]));
        check_val("cnt_strict",    32'(cnt_s),    32'(m_cnt[0]));
        check_val("req_strict",    32'(req_s),    32'(m_phase[0] == 1));
        check_val("err_ns",        32'(err_n),    32'(m_err[1]));
        check_val("sticky_ns",     32'(sticky_n), 32'(m_sticky[1]));
        check_val("cnt_ns",        32'(cnt_n),    32'(m_cnt[1]));
        check_val("req_ns",        32'(req_n),    32'(m_phase[1] == 1));
        if (auto_ack) ack = req_s;
    endtask

    task automatic set_ch(input int c, input logic [7:0] o, input logic [2:0] a, input logic e);
        oh[c*OW +: OW]   = o;
        addr[c*AW +: AW] = a;
        en[c]            = e;
    endtask

    task automatic set_clean();
        set_ch(0, 8'h10, 3'd4, 1'b1);
        set_ch(1, 8'h01, 3'd0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises;
        logic prev_req;

        rst_n = 1'b0; oh = '0; addr = '0; en = '0; chk_en = 1'b0; clr = 1'b0; ack = 1'b0;
        repeat (2) @(negedge clk);
        check_val("reset_err",    32'(err_s),    0);
        check_val("reset_sticky", 32'(sticky_s), 0);
        check_val("reset_cnt",    32'(cnt_s),    0);
        check_val("reset_req",    32'(req_s),    0);
        rst_n = 1'b1;
        model_reset();

        // Clean traffic never flags
        set_clean(); chk_en = 1'b1;
        repeat (6) tick();
        check_val("clean_err", 32'(err_s), 0);
        check_val("clean_cnt", 32'(cnt_s), 0);

        // One multi-hot cycle: err_o two edges later, alert one cycle after that
        auto_ack = 1'b0;
        set_ch(0, 8'h18, 3'd4, 1'b1);
        tick();
        check_val("lat_early", 32'(err_s), 0);
        set_clean();
        tick();
        check_val("lat_err",    32'(err_s),    32'h1);
        check_val("lat_cnt",    32'(cnt_s),    1);
        check_val("lat_sticky", 32'(sticky_s), 32'h1);
        tick();
        check_val("err_one_cycle", 32'(err_s),    0);
        check_val("sticky_holds",  32'(sticky_s), 32'h1);
        check_val("req_next",      32'(req_s),    1);

        // Request holds without ack
        repeat (10) tick();
        check_val("req_hold", 32'(req_s), 1);
        ack = 1'b1;
        tick();
        check_val("req_drop_on_ack", 32'(req_s), 0);

        // Error while in ACK yields exactly one further alert
        set_ch(0, 8'h18, 3'd4, 1'b1);
        tick();
        set_clean();
        tick();
        ack = 1'b0;
        auto_ack = 1'b1;
        rises = 0; prev_req = req_s;
        repeat (20) begin
            tick();
            if (req_s && !prev_req) rises++;
            prev_req = req_s;
        end
        check_val("extra_alert_count", 32'(rises), 1);

        // Strict vs non-strict on an enabled all-zero channel
        set_ch(1, 8'h00, 3'd0, 1'b1);
        repeat (2) tick();
        check_val("strict_zero",    32'(err_s[1]), 1);
        check_val("nonstrict_zero", 32'(err_n[1]), 0);
        set_ch(1, 8'h02, 3'd1, 1'b0);
        repeat (2) tick();
        check_val("strict_dis_set",    32'(err_s[1]), 1);
        check_val("nonstrict_dis_set", 32'(err_n[1]), 1);
        set_clean();
        repeat (2) tick();

        // Address mismatch, then same with checking disabled
        set_ch(0, 8'h04, 3'd3, 1'b1);
        repeat (2) tick();
        check_val("addr_err", 32'(err_s[0]), 1);
        chk_en = 1'b0;
        repeat (2) tick();
        check_val("addr_chk_off", 32'(err_s[0]), 0);
        chk_en = 1'b1;
        set_clean();
        repeat (2) tick();

        // Counter saturation and clear under a persistent error
        set_ch(0, 8'h18, 3'd4, 1'b1);
        repeat (300) tick();
        check_val("cnt_sat", 32'(cnt_s), 255);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_val("cnt_clr_busy",    32'(cnt_s),       1);
        check_val("sticky_clr_busy", 32'(sticky_s[0]), 1);
        set_clean();
        repeat (3) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_val("cnt_clr_idle",    32'(cnt_s),    0);
        check_val("sticky_clr_idle", 32'(sticky_s), 0);

        // Random traffic against the reference
        auto_ack = 1'b0;
        repeat (400) begin
            for (int c = 0; c < NC; c++) begin
                int kind;
                logic [2:0] a;
                a    = 3'($urandom_range(0, 7));
                kind = int'($urandom_range(0, 3));
                if (kind <= 1)      set_ch(c, 8'(1) << a, a, 1'b1);
                else if (kind == 2) set_ch(c, 8'h00, a, 1'($urandom_range(0, 1)));
                else                set_ch(c, 8'($urandom), a, 1'($urandom_range(0, 1)));
            end
            chk_en = ($urandom_range(0, 7) != 0);
            clr    = ($urandom_range(0, 31) == 0);
            ack    = 1'($urandom_range(0, 1));
            tick();
        end
        clr = 1'b0; chk_en = 1'b1;

        // Asynchronous reset while a request is raised
        ack = 1'b0;
        set_ch(0, 8'h18, 3'd4, 1'b1);
        tick();
        set_clean();
        for (int i = 0; i < 20 && !req_s; i++) tick();
        check_val("req_reached", 32'(req_s), 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("req_async_drop", 32'(req_s),    0);
        check_val("cnt_async_drop", 32'(cnt_s),    0);
        check_val("sticky_async",   32'(sticky_s), 0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) tick();
        check_val("post_reset_idle", 32'(req_s), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
